bram_sdp: RTL and testbench

- Parametrised simple dual-port block RAM: one write port and one read port, both on a single clock.
- Successor to the fixed 8-bit x 2048 BRAM. Adds configurable width and depth, byte-granular write enables, write-first read-during-write forwarding, and selectable read latency.
- Adds a hardware clear sequencer that fills memory with a constant after reset.
- Used as a line/frame buffer and scratch store between pipeline stages.

---
 rtl/bram_sdp_pkg.sv | 21 ++
 rtl/bram_sdp_array.sv | 36 +++
 rtl/bram_sdp.sv | 188 ++++++++++++++++++
 tb/tb_bram_sdp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_sdp_pkg.sv
// Shared types and helpers for the bram_sdp simple dual-port RAM.
// The optional per-lane parity (BRAM_SDP_PARITY_EN) uses even_parity below.
package bram_sdp_pkg;

    typedef enum logic {CLEAR, RUN} state_t;

    function automatic int lane_count(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    // Callers zero-extend the lane; extra zeros do not change parity.
    function automatic logic even_parity(input logic [63:0] lane);
        return ^lane;
    endfunction

    function automatic bit cfg_legal(input int data_w, input int byte_w, input int rd_lat);
        return (byte_w > 0) && (byte_w <= 64) && (data_w % byte_w == 0)
               && (rd_lat == 1 || rd_lat == 2);
    endfunction

endpackage

// File: rtl/bram_sdp_array.sv
// Raw storage: per-lane write enables and a registered read; read returns
// the contents before any same-cycle write (forwarding is done by the top).
module bram_sdp_array #(
    parameter int ADDR_W = 11,
    parameter int NB     = 1,
    parameter int LANE_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NB-1:0]          we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [NB*LANE_W-1:0]   wdata,
    input  logic                   ren,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [NB*LANE_W-1:0]   rdata
);

    logic [NB*LANE_W-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bram_sdp.sv
// Simple dual-port RAM with post-reset clear sequencer, byte enables,
// write-first forwarding and RD_LAT of 1 or 2. Macro BRAM_SDP_PARITY_EN adds lane parity.
module bram_sdp
    import bram_sdp_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 11,
    parameter int                BYTE_W     = 8,
    parameter int                RD_LAT     = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wren,
    input  logic [ADDR_W-1:0]          wraddress,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [DATA_W/BYTE_W-1:0]   byte_en,
    input  logic                       oen,
    input  logic [ADDR_W-1:0]          rdaddress,
    output logic [DATA_W-1:0]          data_out,
`ifdef BRAM_SDP_PARITY_EN
    output logic [DATA_W/BYTE_W-1:0]   parity_err,
`endif
    output logic                       rd_valid,
    output logic                       busy
);

    localparam int NB = lane_count(DATA_W, BYTE_W);
`ifdef BRAM_SDP_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int LANE_W = BYTE_W + PB;

    if (!cfg_legal(DATA_W, BYTE_W, RD_LAT)) begin : g_bad_cfg
        $error("bram_sdp: DATA_W must be a multiple of BYTE_W and RD_LAT must be 1 or 2");
    end

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic                run;
    logic                ren;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + ADDR_W'(1);
            if (cnt == {ADDR_W{1'b1}}) begin
                state <= RUN;
            end
        end
    end

    assign busy = rst || (state == CLEAR);
    assign run  = (state == RUN) && !rst;
    assign ren  = oen && run;

    logic [NB*LANE_W-1:0] user_word, init_word, arr_wdata, arr_rdata;
    logic [NB-1:0]        arr_we;
    logic [ADDR_W-1:0]    arr_waddr;

    always_comb begin
        user_word = '0;
        init_word = '0;
        for (int i = 0; i < NB; i++) begin
`ifdef BRAM_SDP_PARITY_EN
            user_word[i*LANE_W +: LANE_W] = {even_parity(64'(data_in[i*BYTE_W +: BYTE_W])),
                                             data_in[i*BYTE_W +: BYTE_W]};
            init_word[i*LANE_W +: LANE_W] = {even_parity(64'(INIT_VALUE[i*BYTE_W +: BYTE_W])),
                                             INIT_VALUE[i*BYTE_W +: BYTE_W]};
`else
            user_word[i*LANE_W +: LANE_W] = data_in[i*BYTE_W +: BYTE_W];
            init_word[i*LANE_W +: LANE_W] = INIT_VALUE[i*BYTE_W +: BYTE_W];
`endif
        end
    end

    always_comb begin
        if (state == CLEAR) begin
            arr_we    = '1;
            arr_waddr = cnt;
            arr_wdata = init_word;
        end else begin
            arr_we    = run ? (byte_en & {NB{wren}}) : '0;
            arr_waddr = wraddress;
            arr_wdata = user_word;
        end
    end

    bram_sdp_array #(
        .ADDR_W (ADDR_W),
        .NB     (NB),
        .LANE_W (LANE_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .ren   (ren),
        .raddr (rdaddress),
        .rdata (arr_rdata)
    );

    // Lanes written at the read address in the read cycle are captured here
    // and override the array's (pre-write) read data.
    logic [NB-1:0]      fwd_hit;
    logic [DATA_W-1:0]  fwd_data;
    logic               v1;

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_hit  <= '0;
            fwd_data <= '0;
            v1       <= 1'b0;
        end else begin
            v1 <= ren;
            if (ren) begin
                fwd_hit  <= (wraddress == rdaddress) ? arr_we : '0;
                fwd_data <= data_in;
            end
        end
    end

    logic [DATA_W-1:0] merged;

    always_comb begin
        merged = '0;
        for (int i = 0; i < NB; i++) begin
            merged[i*BYTE_W +: BYTE_W] = fwd_hit[i] ? fwd_data[i*BYTE_W +: BYTE_W]
                                                    : arr_rdata[i*LANE_W +: BYTE_W];
        end
    end

`ifdef BRAM_SDP_PARITY_EN
    logic [NB-1:0] merged_err, out_err;

    always_comb begin
        merged_err = '0;
        for (int i = 0; i < NB; i++) begin
            merged_err[i] = !fwd_hit[i] &&
                            (arr_rdata[i*LANE_W + BYTE_W] != ^arr_rdata[i*LANE_W +: BYTE_W]);
        end
    end

    assign parity_err = out_err & {NB{rd_valid}};
`endif

    if (RD_LAT == 1) begin : g_lat1
        assign data_out = merged;
        assign rd_valid = v1;
`ifdef BRAM_SDP_PARITY_EN
        assign out_err  = merged_err;
`endif
    end else begin : g_lat2
        logic [DATA_W-1:0] d2;
        logic              v2;
`ifdef BRAM_SDP_PARITY_EN
        logic [NB-1:0]     e2;
`endif
        always_ff @(posedge clk) begin
            if (rst) begin
                d2 <= '0;
                v2 <= 1'b0;
`ifdef BRAM_SDP_PARITY_EN
                e2 <= '0;
`endif
            end else begin
                v2 <= v1;
                if (v1) begin
                    d2 <= merged;
`ifdef BRAM_SDP_PARITY_EN
                    e2 <= merged_err;
`endif
                end
            end
        end
        assign data_out = d2;
        assign rd_valid = v2;
`ifdef BRAM_SDP_PARITY_EN
        assign out_err  = e2;
`endif
    end

endmodule

// File: tb/tb_bram_sdp.sv
// Bench for bram_sdp: RD_LAT=1 and RD_LAT=2 instances share stimulus and are
// checked every cycle against a behavioural memory model plus literal expectations.
module tb_bram_sdp;

    localparam logic [15:0] INIT = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        wren;
    logic [3:0]  wraddress;
    logic [15:0] data_in;
    logic [1:0]  byte_en;
    logic        oen;
    logic [3:0]  rdaddress;
    logic [15:0] data_out1, data_out2;
    logic        rd_valid1, rd_valid2;
    logic        busy1, busy2;
`ifdef BRAM_SDP_PARITY_EN
    logic [1:0]  perr1, perr2;
`endif

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    bram_sdp #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .RD_LAT(1), .INIT_VALUE(INIT)) u_l1 (
        .clk(clk), .rst(rst), .wren(wren), .wraddress(wraddress), .data_in(data_in),
        .byte_en(byte_en), .oen(oen), .rdaddress(rdaddress), .data_out(data_out1),
`ifdef BRAM_SDP_PARITY_EN
        .parity_err(perr1),
`endif
        .rd_valid(rd_valid1), .busy(busy1));

    bram_sdp #(.DATA_W(16), .ADDR_W(4), .BYTE_W(8), .RD_LAT(2), .INIT_VALUE(INIT)) u_l2 (
        .clk(clk), .rst(rst), .wren(wren), .wraddress(wraddress), .data_in(data_in),
        .byte_en(byte_en), .oen(oen), .rdaddress(rdaddress), .data_out(data_out2),
`ifdef BRAM_SDP_PARITY_EN
        .parity_err(perr2),
`endif
        .rd_valid(rd_valid2), .busy(busy2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        for (int b = 0; b < 2; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Model: memory contents, remaining clear cycles, and the held/valid
    // outputs for one- and two-cycle read latency.
    logic [15:0] m_mem [16];
    int          clr_left = 0;
    bit          e1v = 0, e2v = 0;
    logic [15:0] e1d = '0, e2d = '0;

    always @(posedge clk) begin
        bit nv;
        logic [15:0] nd;
        nv = 1'b0;
        nd = '0;
        if (rst) begin
            for (int a = 0; a < 16; a++) m_mem[a] = INIT;
            clr_left = 16;
            e1v = 0; e2v = 0; e1d = '0; e2d = '0;
        end else begin
            if (clr_left == 0) begin
                if (oen) begin
                    nv = 1'b1;
                    nd = m_mem[rdaddress];
                    if (wren && wraddress == rdaddress) nd = merge(nd, data_in, byte_en);
                end
                if (wren) m_mem[wraddress] = merge(m_mem[wraddress], data_in, byte_en);
            end else begin
                clr_left--;
            end
            e2v = e1v;
            if (e1v) e2d = e1d;
            e1v = nv;
            if (nv) e1d = nd;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("busy_l1", busy1, rst || clr_left != 0);
            chk("busy_l2", busy2, rst || clr_left != 0);
            chk("rd_valid_l1", rd_valid1, e1v);
            chk("rd_valid_l2", rd_valid2, e2v);
            chk("data_out_l1", data_out1, e1d);
            chk("data_out_l2", data_out2, e2d);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wren = 1'b1; wraddress = a; data_in = d; byte_en = be;
        step();
        wren = 1'b0; byte_en = 2'b00;
    endtask

    task automatic rd(input logic [3:0] a);
        oen = 1'b1; rdaddress = a;
        step();
        oen = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy1 && n < 40) begin
            step();
            n++;
        end
    endtask

    int n;
    logic [15:0] lat_exp [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h3333};

    initial begin
        rst = 1'b1; wren = 1'b0; wraddress = '0; data_in = '0; byte_en = '0;
        oen = 1'b0; rdaddress = '0;
        step();
        rst = 1'b0;
        checking = 1'b1;
        chk("reset_data_out", data_out1, 16'h0000);
        chk("reset_rd_valid", rd_valid1, 1'b0);
        wait_busy(n);
        chk("busy_cycles", n, 16);

        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            chk("sweep_valid", rd_valid1, 1'b1);
            chk("sweep_data", data_out1, 16'hA5A5);
        end

        wr(4'd3, 16'h1234, 2'b11);
        wr(4'd3, 16'hFF00, 2'b10);
        wr(4'd3, 16'hBEEF, 2'b00);
        rd(4'd3);
        chk("byte_en_data", data_out1, 16'hFF34);

        wr(4'd5, 16'h00AA, 2'b11);
        wren = 1'b1; wraddress = 4'd5; data_in = 16'h0055; byte_en = 2'b01;
        oen = 1'b1; rdaddress = 4'd5;
        step();
        wren = 1'b0; oen = 1'b0; byte_en = 2'b00;
        chk("rdw_data", data_out1, 16'h0055);
        step();
        chk("rdw_hold_valid", rd_valid1, 1'b0);
        chk("rdw_hold_data", data_out1, 16'h0055);

        wr(4'd1, 16'h1111, 2'b11);
        wr(4'd2, 16'h2222, 2'b11);
        wr(4'd3, 16'h3333, 2'b11);
        for (int k = 0; k < 5; k++) begin
            oen = (k < 3);
            rdaddress = 4'(k + 1);
            step();
            chk("lat2_valid", rd_valid2, (k >= 1 && k <= 3));
            if (k >= 1) chk("lat2_data", data_out2, lat_exp[k-1]);
        end
        oen = 1'b0;

        // Reset again, then interrupt the clear at its eighth cycle.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        wren = 1'b1; wraddress = 4'd4; data_in = 16'hDEAD; byte_en = 2'b11;
        step();
        rst = 1'b0;
        wait_busy(n);
        wren = 1'b0; byte_en = 2'b00;
        chk("busy_after_midclear", n, 16);
        rd(4'd4);
        chk("busy_write_ignored", data_out1, 16'hA5A5);
        rd(4'd3);
        chk("midclear_cleared", data_out1, 16'hA5A5);

        for (int c = 0; c < 80; c++) begin
            wren = 1'($urandom_range(0, 1));
            oen = 1'($urandom_range(0, 1));
            byte_en = 2'($urandom_range(0, 3));
            data_in = 16'($urandom);
            wraddress = 4'($urandom_range(0, 15));
            rdaddress = ($urandom_range(0, 2) == 0) ? wraddress : 4'($urandom_range(0, 15));
            step();
        end
        wren = 1'b0; oen = 1'b0; byte_en = 2'b00;
        step();
        step();

`ifdef BRAM_SDP_PARITY_EN
        wr(4'd2, 16'h0F0F, 2'b11);
        rd(4'd2);
        chk("parity_clean", perr1, 2'b00);
        u_l1.u_array.mem[2][0] = ~u_l1.u_array.mem[2][0];
        u_l2.u_array.mem[2][0] = ~u_l2.u_array.mem[2][0];
        m_mem[2][0] = ~m_mem[2][0];
        rd(4'd2);
        chk("parity_valid", rd_valid1, 1'b1);
        chk("parity_err", perr1, 2'b01);
        step();
`endif

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
